// File: rtl/asyncf_rd_drain.sv
// ---------------------------------------------------------------------------
// asyncf_rd_drain
// Read-side consumer for the async FIFO, entirely in the read clock domain.
// It pops words from the FIFO read port whenever enabled and there is buffer
// space. The words are re-presented on a valid/ready stream through a
// 2-entry buffer, and the block counts every word it pops.
//
// Optional feature macro: ASYNCF_RD_PARITY_EN
//   When defined, rdata[DSIZE-1] is an even-parity bit over the lower bits.
//   Each popped word is checked, and par_err is a sticky error flag.
//   When undefined, no checker is built and par_err is tied to 0.
//
// Ports:
//   rclk      in   read-domain clock, rising edge
//   rrst      in   synchronous active-high reset
//   en        in   drain enable
//   rempty    in   FIFO empty flag
//   rdata     in   FIFO head word (first-word-fall-through)
//   rinc      out  FIFO pop strobe (combinational)
//   m_valid   out  output word valid
//   m_data    out  output word
//   m_ready   in   downstream accept
//   rd_count  out  words popped since reset (wrapping)
//   busy      out  buffer non-empty
//   par_err   out  sticky parity error
// ---------------------------------------------------------------------------
module asyncf_rd_drain #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy,
  output logic             par_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t             r_occ;
  occ_t             w_occ_next;
  logic [DSIZE-1:0] r_slot0;
  logic [DSIZE-1:0] r_slot1;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_load0;
  logic w_load1;
  logic w_shift;

  // The pop term is taken straight from the state so there is no ready->rinc path.
  assign w_pop  = (r_occ != S_EMPTY) & m_ready;
  assign w_push = rinc;

  // Occupancy state register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_occ <= S_EMPTY;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  // Next occupancy: occ + push - pop
  always_comb begin
    w_occ_next = r_occ;
    case (r_occ)
      S_EMPTY: if (w_push) w_occ_next = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_occ_next = S_TWO;
        else if (!w_push && w_pop) w_occ_next = S_EMPTY;
      end
      S_TWO:   if (w_pop) w_occ_next = S_ONE;
      default: w_occ_next = S_EMPTY;
    endcase
  end

  // Pop strobe, stream valid and slot steering
  always_comb begin
    rinc    = 1'b0;
    m_valid = 1'b0;
    w_load0 = 1'b0;
    w_load1 = 1'b0;
    w_shift = 1'b0;
    m_valid = (r_occ != S_EMPTY);
    rinc    = en & ~rempty & (r_occ != S_TWO) & ~rrst;
    case (r_occ)
      S_EMPTY: w_load0 = rinc;
      S_ONE: begin
        // On a simultaneous push and pop, the new word goes straight to the head.
        w_load0 = rinc & w_pop;
        w_load1 = rinc & ~w_pop;
      end
      S_TWO:   w_shift = w_pop;
      default: ;
    endcase
  end

  // Buffer slots; slot0 is the head presented on m_data
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      if (w_load0)      r_slot0 <= rdata;
      else if (w_shift) r_slot0 <= r_slot1;
      if (w_load1)      r_slot1 <= rdata;
    end
  end

  // Popped-word counter, wraps silently
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_count <= '0;
    end else if (rinc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef ASYNCF_RD_PARITY_EN
  logic r_par_err;
  logic w_par_bad;

  // Even parity across the whole word, including the parity bit, must XOR to 0.
  assign w_par_bad = ^rdata;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_par_err <= 1'b0;
    end else if (rinc && w_par_bad) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  assign m_data   = r_slot0;
  assign rd_count = r_count;
  assign busy     = m_valid;

endmodule

// File: tb/tb_asyncf_rd_drain.sv
// Testbench for asyncf_rd_drain. It models the FIFO as a queue of source words.
// The buffer is modelled as a queue of words popped but not yet delivered.
module tb_asyncf_rd_drain;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned CNT_W = 4;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             en;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
  logic [CNT_W-1:0] rd_count;
  logic             busy;
  logic             par_err;

  always #5 rclk = ~rclk;

  asyncf_rd_drain #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .en      (en),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .rd_count(rd_count),
    .busy    (busy),
    .par_err (par_err)
  );

  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE-1:0] exp_q[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_par;
  int               n_chk;
  int               n_fail;
  bit               mon_on;
  int               rdy_mode;
  bit               rdy_val;
  bit               tog;
  bit               rnd_rdy;
  bit               gap;
  int               gap_pct;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive the FIFO face and the downstream ready from the current model state.
  function automatic void apply();
    rempty  = (src_q.size() == 0) || gap;
    rdata   = rempty ? DSIZE'($urandom) : src_q[0];
    m_ready = (rdy_mode == 0) ? rdy_val : (rdy_mode == 1) ? tog : rnd_rdy;
  endfunction

  // One clock cycle. Sample at the negedge, then update the model just after the edge.
  task automatic step();
    logic             s_rinc;
    logic             s_rst;
    logic [DSIZE-1:0] s_data;
    @(negedge rclk);
    s_rinc = rinc;
    s_rst  = rrst;
    s_data = rdata;
    @(posedge rclk);
    #1;
    if (s_rst) begin
      exp_q.delete();
      m_cnt = '0;
      m_par = 1'b0;
    end else if (s_rinc === 1'b1) begin
      if (src_q.size() > 0) src_q.delete(0);
      exp_q.push_back(s_data);
      m_cnt = m_cnt + CNT_W'(1);
`ifdef ASYNCF_RD_PARITY_EN
      if (^s_data) m_par = 1'b1;
`endif
    end
    tog     = ~tog;
    rnd_rdy = 1'($urandom_range(0, 1));
    gap     = ($urandom_range(0, 99) < gap_pct);
    apply();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    chk("drain_left", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  // Monitor: per-cycle rules, plus an in-order scoreboard compare on each handshake.
  always @(negedge rclk) begin
    if (mon_on) begin
      logic e_rinc;
      e_rinc = en & ~rempty & (exp_q.size() < 2) & ~rrst;
      chk("rinc", 32'(rinc), 32'(e_rinc));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
      chk("busy", 32'(busy), 32'(exp_q.size() > 0));
      chk("rd_count", 32'(rd_count), 32'(m_cnt));
      chk("par_err", 32'(par_err), 32'(m_par));
      if (m_valid === 1'b1 && m_ready === 1'b1 && exp_q.size() > 0) begin
        chk("m_data", 32'(m_data), 32'(exp_q[0]));
        exp_q.delete(0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; mon_on = 0;
    m_cnt = '0; m_par = 1'b0;
    en = 1'b0; rrst = 1'b1;
    rdy_mode = 0; rdy_val = 1'b1; tog = 1'b0; rnd_rdy = 1'b0;
    gap = 1'b0; gap_pct = 0;
    apply();
    repeat (3) step();
    rrst = 1'b0;
    mon_on = 1'b1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);

    // Three words delivered in order, with ready held high
    src_q = '{8'h11, 8'h22, 8'h33};
    en = 1'b1;
    apply();
    repeat (6) step();
    chk("t1_count", 32'(rd_count), 32'd3);
    chk("t1_rinc_idle", 32'(rinc), 32'd0);
    chk("t1_valid_idle", 32'(m_valid), 32'd0);

    // Stalled downstream: only two pops, and the head is held stable
    rdy_val = 1'b0;
    src_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    apply();
    repeat (6) step();
    chk("t2_count_stalled", 32'(rd_count), 32'd5);
    chk("t2_head", 32'(m_data), 32'hA1);
    chk("t2_valid", 32'(m_valid), 32'd1);
    rdy_val = 1'b1;
    apply();
    drain(30);
    chk("t2_count_all", 32'(rd_count), 32'd8);

    // 100 random words with ready toggling every cycle; 108 pops wrap to 12
    rdy_mode = 1;
    for (int i = 0; i < 100; i++) src_q.push_back(DSIZE'($urandom));
    apply();
    drain(400);
    chk("t3_count_wrap", 32'(rd_count), 32'd12);

    // Drop en while the buffer is full; buffered words still drain
    rdy_mode = 0; rdy_val = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(DSIZE'($urandom));
    apply();
    repeat (3) step();
    en = 1'b0;
    apply();
    step();
    rdy_val = 1'b1;
    apply();
    repeat (4) step();
    chk("t4_valid_off", 32'(m_valid), 32'd0);
    chk("t4_src_left", 32'(src_q.size()), 32'd4);
    en = 1'b1;
    apply();
    drain(30);

    // Random ready, random en, and FIFO empty gaps
    rdy_mode = 2; gap_pct = 30;
    for (int i = 0; i < 200; i++) src_q.push_back(DSIZE'($urandom));
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() == 0 && exp_q.size() == 0) break;
      en = ($urandom_range(0, 3) != 0);
      apply();
      step();
    end
    en = 1'b1; gap_pct = 0;
    apply();
    drain(30);

    // Reset with the buffer full discards the buffered words
    rdy_mode = 0; rdy_val = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(DSIZE'($urandom));
    apply();
    repeat (3) step();
    chk("t6_full_valid", 32'(m_valid), 32'd1);
    rrst = 1'b1;
    apply();
    step();
    rrst = 1'b0;
    apply();
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_rd_count", 32'(rd_count), 32'd0);
    chk("t6_m_data", 32'(m_data), 32'd0);
    chk("t6_par_err", 32'(par_err), 32'd0);
    rdy_val = 1'b1;
    apply();
    drain(30);

    // Seventeen pops after reset wrap a 4-bit counter to 1
    rrst = 1'b1;
    apply();
    step();
    rrst = 1'b0;
    for (int i = 0; i < 17; i++) src_q.push_back(DSIZE'($urandom));
    apply();
    drain(60);
    chk("t7_wrap", 32'(rd_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
